led_scan_capture: RTL

//   Receive end of the 16x16x2 LED board GPIO_1 row-scan bus. Samples the 36-bit word
//   (row select + 16 green + 16 red column bits), deglitches it, rebuilds the full red and

---
 rtl/led_scan_pkg.sv | 33 +++
 rtl/gpio_word_debounce.sv | 52 +++++
 rtl/led_scan_capture.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared widths, frame types and bit-mapping helpers for the LED scan capture path.
package led_scan_pkg;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned COLS    = 16;
  localparam int unsigned GPIO_W  = 36;
  localparam int unsigned ROW_LSB = 32;
  localparam int unsigned GRN_LSB = 16;
  localparam int unsigned RED_LSB = 0;
  localparam int unsigned ROW_W   = 4;

  typedef logic [COLS-1:0]            pixel_row_t;
  typedef logic [ROWS-1:0][COLS-1:0]  frame_t;
  typedef logic [GPIO_W-1:0]          gpio_word_t;
  typedef logic [ROW_W-1:0]           row_idx_t;

  // Publish sequencer: a completed scan spends exactly one cycle in PUB_COPY.
  typedef enum logic {
    PUB_IDLE = 1'b0,
    PUB_COPY = 1'b1
  } pub_state_t;

  // Column c of a pixel row is carried on field bit (COLS-1-c).
  function automatic pixel_row_t gpio_to_row(input pixel_row_t field);
    return {<<{field}};
  endfunction

  // Row select carried in the top nibble of the scan word.
  function automatic row_idx_t gpio_row(input gpio_word_t word);
    return word[ROW_LSB +: ROW_W];
  endfunction

endpackage

// File: rtl/gpio_word_debounce.sv
// Two-flop synchroniser plus dwell counter; flags a word once it has been stable long enough.
module gpio_word_debounce
  import led_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] word,
  output logic              accept_c
);

  localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [CNT_W-1:0]  dwell;

  // Synchronise the whole bus into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  // Dwell count: sync1 is the next synchronised value, so a mismatch means sync2 is changing.
  // Saturating one past the hit value keeps the accept strobe to a single cycle per dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
    end else if (sync1 != sync2) begin
      dwell <= '0;
    end else if (dwell != CNT_MAX) begin
      dwell <= dwell + CNT_W'(1);
    end
  end

  // Stable word and its one-shot accept.
  always_comb begin
    word     = sync2;
    accept_c = (dwell == CNT_HIT);
  end

endmodule

// File: rtl/led_scan_capture.sv
// Rebuilds red/green LED frames from the row-scan bus and publishes one frame per clean scan.
module led_scan_capture
  import led_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [35:0]       GPIO_1,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels,
  output logic              frame_done,
  output logic [15:0]       row_valid,
  output logic              skip_err,
  output logic [7:0]        frame_count
);

  gpio_word_t word;
  logic       accept_c;

  row_idx_t   acc_row_c;
  pixel_row_t acc_red_c;
  pixel_row_t acc_grn_c;
  logic       repeat_c;
  logic       in_order_c;
  logic       last_row_c;
  logic       full_c;

  frame_t     shadow_red;
  frame_t     shadow_grn;

  pub_state_t state;
  pub_state_t state_n;
  row_idx_t   exp_row;
  row_idx_t   exp_row_n;
  row_idx_t   last_row;
  row_idx_t   last_row_n;
  logic       last_valid;
  logic       last_valid_n;
  pixel_row_t row_valid_n;
  logic       skip_err_n;

  gpio_word_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk      (CLK),
    .rst      (RST),
    .gpio_in  (GPIO_1),
    .word     (word),
    .accept_c (accept_c)
  );

  // Decode the accepted word and classify its row against the scan history.
  always_comb begin
    acc_row_c  = gpio_row(word);
    acc_red_c  = gpio_to_row(word[RED_LSB +: COLS]);
    acc_grn_c  = gpio_to_row(word[GRN_LSB +: COLS]);
    repeat_c   = last_valid && (acc_row_c == last_row);
    in_order_c = (acc_row_c == exp_row);
    last_row_c = (acc_row_c == row_idx_t'(ROWS - 1));
    full_c     = &row_valid[ROWS-2:0];
  end

  // Shadow frame collects rows as they are accepted, including overwrites.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_red <= '0;
      shadow_grn <= '0;
    end else if (accept_c) begin
      shadow_red[acc_row_c] <= acc_red_c;
      shadow_grn[acc_row_c] <= acc_grn_c;
    end
  end

  // Row tracking and publish sequencing: next-state decisions.
  always_comb begin
    state_n      = PUB_IDLE;
    exp_row_n    = exp_row;
    last_row_n   = last_row;
    last_valid_n = last_valid;
    row_valid_n  = row_valid;
    skip_err_n   = skip_err;

    if (accept_c) begin
      last_row_n   = acc_row_c;
      last_valid_n = 1'b1;
      if (repeat_c) begin
        // Same row again with new data: overwrite only, scan position unchanged.
        row_valid_n[acc_row_c] = 1'b1;
      end else begin
        exp_row_n = acc_row_c + row_idx_t'(1);
        if (!in_order_c) begin
          skip_err_n = 1'b1;
        end
        if (last_row_c) begin
          // Closing row: publish only if every earlier row of this scan arrived.
          row_valid_n = '0;
          if (full_c) begin
            state_n = PUB_COPY;
          end else begin
            skip_err_n = 1'b1;
          end
        end else begin
          row_valid_n[acc_row_c] = 1'b1;
        end
      end
    end
  end

  // Row tracking and publish sequencing: state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= PUB_IDLE;
      exp_row    <= '0;
      last_row   <= '0;
      last_valid <= 1'b0;
      row_valid  <= '0;
      skip_err   <= 1'b0;
    end else begin
      state      <= state_n;
      exp_row    <= exp_row_n;
      last_row   <= last_row_n;
      last_valid <= last_valid_n;
      row_valid  <= row_valid_n;
      skip_err   <= skip_err_n;
    end
  end

  // Published frame, done pulse and frame counter update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RedPixels   <= '0;
      GrnPixels   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= (state == PUB_COPY);
      if (state == PUB_COPY) begin
        RedPixels   <= shadow_red;
        GrnPixels   <= shadow_grn;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
